// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: round-robin sharing of one DDR burst port among four cache clients.
// Latency: grant/burst request appear 1 cycle after a winner is picked in IDLE; 2 idle cycles between bursts.
// Backpressure: requests wait while a burst is open; one whole burst per grant, no preemption.
module ddr_burst_arbiter #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH     = 16,
  parameter int INSTR_BLEN     = 16,
  parameter int DATA_BLEN      = 16,
  parameter int JMP_BLEN       = 1,
  parameter int TIMEOUT        = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] instr_read_addr,
  input  logic                      data_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] data_read_addr,
  input  logic                      data_store_req,
  input  logic [DDR_ADDR_WIDTH-1:0] data_write_addr,
  input  logic                      jmp_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] jmp_read_addr,
  input  logic [DATA_WIDTH-1:0]     data_to_ddr,
  output logic                      rd_burst_req,
  output logic                      wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [9:0]                rd_burst_len,
  output logic [9:0]                wr_burst_len,
  input  logic [DATA_WIDTH-1:0]     rd_burst_data,
  input  logic                      rd_burst_data_valid,
  input  logic                      rd_burst_finish,
  output logic [DATA_WIDTH-1:0]     wr_burst_data,
  input  logic                      wr_burst_data_req,
  input  logic                      wr_burst_finish,
  output logic [3:0]                grant,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [3:0]                rd_valid,
  output logic [9:0]                rd_cnt_data,
  output logic                      wr_data_req,
  output logic [3:0]                state_interface_module,
  output logic                      timeout_err
);

  // Timeout counter only needs to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] CL_INSTR = 2'd0;
  localparam logic [1:0] CL_DREAD = 2'd1;
  localparam logic [1:0] CL_STORE = 2'd2;
  localparam logic [1:0] CL_JMP   = 2'd3;

  // Interface-state codes seen by data_cache.
  localparam logic [3:0] CODE_IDLE  = 4'd0;
  localparam logic [3:0] CODE_INSTR = 4'd5;
  localparam logic [3:0] CODE_DREAD = 4'd6;
  localparam logic [3:0] CODE_JMP   = 4'd7;
  localparam logic [3:0] CODE_STORE = 4'd9;

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                ptr_q, ptr_d;
  logic [3:0]                armed_q, armed_d;
  logic [1:0]                win_q, win_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [9:0]                len_q, len_d;
  logic [3:0]                grant_q, grant_d;
  logic [3:0]                code_q, code_d;
  logic                      rd_req_q, rd_req_d;
  logic                      wr_req_q, wr_req_d;
  logic [9:0]                cnt_q, cnt_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic                      err_q, err_d;

  logic [3:0]                req_vec;
  logic [3:0]                elig;
  logic                      pick_vld;
  logic [1:0]                pick_idx;
  logic [1:0]                scan_idx;
  logic [DDR_ADDR_WIDTH-1:0] pick_addr;
  logic [9:0]                pick_len;
  logic [3:0]                pick_code;
  logic                      win_is_wr;
  logic                      fin_sel;

  assign req_vec   = {jmp_read_req, data_store_req, data_read_req, instr_read_req};
  // A level request that already had its burst stays ineligible until it drops.
  assign elig      = req_vec & armed_q;
  assign win_is_wr = (win_q == CL_STORE);
  // Only the finish pulse matching the open burst's direction closes it.
  assign fin_sel   = win_is_wr ? wr_burst_finish : rd_burst_finish;

  // Round-robin pick: first eligible client from the pointer upward, wrapping mod 4.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    scan_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (elig[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // Address, burst length and interface code belonging to the candidate winner.
  always_comb begin
    pick_addr = instr_read_addr;
    pick_len  = 10'(INSTR_BLEN);
    pick_code = CODE_INSTR;
    case (pick_idx)
      CL_INSTR: begin
        pick_addr = instr_read_addr;
        pick_len  = 10'(INSTR_BLEN);
        pick_code = CODE_INSTR;
      end
      CL_DREAD: begin
        pick_addr = data_read_addr;
        pick_len  = 10'(DATA_BLEN);
        pick_code = CODE_DREAD;
      end
      CL_STORE: begin
        pick_addr = data_write_addr;
        pick_len  = 10'(DATA_BLEN);
        pick_code = CODE_STORE;
      end
      default: begin
        pick_addr = jmp_read_addr;
        pick_len  = 10'(JMP_BLEN);
        pick_code = CODE_JMP;
      end
    endcase
  end

  // Next-state and registered-output logic for IDLE -> GRANT -> BURST -> DONE.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    armed_d  = armed_q;
    win_d    = win_q;
    addr_d   = addr_q;
    len_d    = len_q;
    grant_d  = grant_q;
    code_d   = code_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d    = pick_idx;
          addr_d   = pick_addr;
          len_d    = pick_len;
          grant_d  = 4'b0001 << pick_idx;
          code_d   = pick_code;
          rd_req_d = (pick_idx != CL_STORE);
          wr_req_d = (pick_idx == CL_STORE);
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = S_GRANT;
        end
      end

      S_GRANT: begin
        state_d = S_BURST;
      end

      S_BURST: begin
        if (rd_burst_data_valid && !win_is_wr && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 10'd1;
        end
        if (fin_sel) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          grant_d  = 4'b0000;
          code_d   = CODE_IDLE;
          state_d  = S_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Controller never finished: abandon the burst and flag it.
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          grant_d  = 4'b0000;
          code_d   = CODE_IDLE;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        ptr_d          = win_q + 2'd1;
        armed_d[win_q] = 1'b0;
        state_d        = S_IDLE;
      end
    endcase

    // Any cycle with the request low re-arms that client, even in DONE.
    armed_d = armed_d | ~req_vec;
  end

  // State and output registers; reset aborts any open burst immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      armed_q  <= 4'hF;
      win_q    <= 2'd0;
      addr_q   <= '0;
      len_q    <= '0;
      grant_q  <= '0;
      code_q   <= CODE_IDLE;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      armed_q  <= armed_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      grant_q  <= grant_d;
      code_q   <= code_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign rd_burst_req           = rd_req_q;
  assign wr_burst_req           = wr_req_q;
  assign rd_burst_addr          = addr_q;
  assign wr_burst_addr          = addr_q;
  assign rd_burst_len           = len_q;
  assign wr_burst_len           = len_q;
  assign wr_burst_data          = data_to_ddr;
  assign grant                  = grant_q;
  assign rd_data                = rd_burst_data;
  assign rd_valid               = grant_q & {4{rd_burst_data_valid}};
  assign rd_cnt_data            = cnt_q;
  assign wr_data_req            = wr_burst_data_req & grant_q[CL_STORE];
  assign state_interface_module = code_q;
  assign timeout_err            = err_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Bench for ddr_burst_arbiter: randomized request rounds, DDR controller model, scoreboard monitor.
// Expected grants come from a round-robin model fed by the stimulus; the monitor pops them on each new grant.
// Controller model answers bursts with random gaps; timeout and mid-burst reset are driven directly.
module tb_ddr_burst_arbiter;
  localparam int AW = 28;
  localparam int DW = 16;

  typedef struct {
    int         client;
    logic [27:0] addr;
    int         blen;
    int         code;
    bit         b2b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_read_req = 1'b0, data_read_req = 1'b0, data_store_req = 1'b0, jmp_read_req = 1'b0;
  logic [AW-1:0] instr_read_addr = '0, data_read_addr = '0, data_write_addr = '0, jmp_read_addr = '0;
  logic [DW-1:0] data_to_ddr = '0, rd_burst_data = '0;
  logic          rd_burst_data_valid = 1'b0, rd_burst_finish = 1'b0;
  logic          wr_burst_data_req = 1'b0, wr_burst_finish = 1'b0;
  logic          rd_burst_req, wr_burst_req;
  logic [AW-1:0] rd_burst_addr, wr_burst_addr;
  logic [9:0]    rd_burst_len, wr_burst_len, rd_cnt_data;
  logic [DW-1:0] wr_burst_data, rd_data;
  logic [3:0]    grant, rd_valid, state_interface_module;
  logic          wr_data_req, timeout_err;

  int   n_cmp = 0, n_bad = 0, cyc = 0, last_fin = 0, n_grants = 0, m_ptr = 0;
  bit   ctl_mute = 1'b0;
  exp_t exp_q[$];
  logic [AW-1:0] addr_tbl[4];

  ddr_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .instr_read_req(instr_read_req), .instr_read_addr(instr_read_addr),
    .data_read_req(data_read_req), .data_read_addr(data_read_addr),
    .data_store_req(data_store_req), .data_write_addr(data_write_addr),
    .jmp_read_req(jmp_read_req), .jmp_read_addr(jmp_read_addr),
    .data_to_ddr(data_to_ddr),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_finish(rd_burst_finish), .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .grant(grant), .rd_data(rd_data), .rd_valid(rd_valid), .rd_cnt_data(rd_cnt_data),
    .wr_data_req(wr_data_req), .state_interface_module(state_interface_module),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int blen_of(input int c);
    return (c == 3) ? 1 : 16;
  endfunction

  function automatic int code_of(input int c);
    case (c)
      0: return 5;
      1: return 6;
      2: return 9;
      default: return 7;
    endcase
  endfunction

  // Round-robin reference: clients raised together are served in cyclic order from the pointer.
  task automatic model_round(input logic [3:0] set);
    exp_t e;
    bit   first;
    int   last, c;
    first = 1'b1;
    last  = m_ptr;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (set[c]) begin
        e.client = c; e.addr = addr_tbl[c]; e.blen = blen_of(c);
        e.code = code_of(c); e.b2b = !first;
        exp_q.push_back(e);
        first = 1'b0;
        last  = c;
      end
    end
    m_ptr = (last + 1) % 4;
  endtask

  task automatic set_reqs(input logic [3:0] r);
    instr_read_req = r[0]; data_read_req = r[1]; data_store_req = r[2]; jmp_read_req = r[3];
  endtask

  task automatic drive_addrs();
    instr_read_addr = addr_tbl[0]; data_read_addr = addr_tbl[1];
    data_write_addr = addr_tbl[2]; jmp_read_addr = addr_tbl[3];
  endtask

  task automatic run_round(input logic [3:0] set, input bit rnd, input int hold);
    int waited;
    if (rnd) for (int c = 0; c < 4; c++) addr_tbl[c] = AW'($urandom);
    model_round(set);
    @(posedge clk); #1;
    drive_addrs();
    set_reqs(set);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(exp_q.size() == 0 && grant == 4'b0) && waited < 5000);
    if (waited >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL round_timeout: %0d grants still pending after 5000 cycles", exp_q.size());
      exp_q.delete();
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    set_reqs(4'b0000);
    repeat (3) @(posedge clk);
  endtask

  // DDR controller model: serves each burst, also pulses the wrong-direction finish first.
  bit ctl_wr;
  int ctl_n, ctl_w;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && !ctl_mute && (rd_burst_req || wr_burst_req)) begin
        ctl_wr = wr_burst_req;
        ctl_n  = ctl_wr ? int'(wr_burst_len) : int'(rd_burst_len);
        @(posedge clk); #1;
        if (ctl_wr) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
        @(posedge clk); #1;
        rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        for (int i = 0; i < ctl_n; i++) begin
          if (ctl_wr) begin
            wr_burst_data_req = 1'b1; data_to_ddr = DW'($urandom);
          end else begin
            rd_burst_data_valid = 1'b1; rd_burst_data = DW'($urandom);
          end
          @(negedge clk);
          if (ctl_wr) begin
            chk("wr_data_req", wr_data_req, 1);
            chk("wr_burst_data", wr_burst_data, data_to_ddr);
          end
          @(posedge clk); #1;
          wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        if (ctl_wr) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
        @(negedge clk);
        chk("burst_req_held", ctl_wr ? wr_burst_req : rd_burst_req, 1);
        @(posedge clk); #1;
        rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
        ctl_w = 0;
        while ((rd_burst_req || wr_burst_req) && ctl_w < 10) begin @(negedge clk); ctl_w++; end
        chk("burst_req_drop", {rd_burst_req, wr_burst_req}, 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each new grant and checks routing while it is held.
  logic [3:0] mon_pg = 4'b0;
  int         mon_beats = 0;
  bit         mon_rd = 1'b1;
  int         mon_client = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_pg = 4'b0; mon_beats = 0;
      end else begin
        if (mon_rd ? rd_burst_finish : wr_burst_finish) last_fin = cyc;
        if (grant != 4'b0 && mon_pg == 4'b0) begin
          n_grants++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_grant: got %b expected no grant", grant);
          end else begin
            e = exp_q.pop_front();
            mon_client = e.client;
            mon_rd     = (e.client != 2);
            mon_beats  = 0;
            chk("grant_onehot", grant, 64'(1) << e.client);
            chk("burst_addr", mon_rd ? rd_burst_addr : wr_burst_addr, e.addr);
            chk("burst_len", mon_rd ? rd_burst_len : wr_burst_len, e.blen);
            chk("state_code", state_interface_module, e.code);
            chk("burst_dir", {rd_burst_req, wr_burst_req}, mon_rd ? 2'b10 : 2'b01);
            chk("rd_cnt_at_grant", rd_cnt_data, 0);
            if (e.b2b) chk("turnaround", cyc - last_fin, 3);
          end
        end
        if (grant != 4'b0 && rd_burst_data_valid) begin
          mon_beats++;
          chk("rd_valid_route", rd_valid, 64'(1) << mon_client);
          chk("rd_data", rd_data, rd_burst_data);
        end
        if (grant == 4'b0 && mon_pg != 4'b0) begin
          chk("done_state_code", state_interface_module, 0);
          if (mon_rd) chk("rd_cnt_data", rd_cnt_data, mon_beats);
        end
        mon_pg = grant;
      end
    end
  end

  initial begin
    #600000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, w, hi;
    // Reset state.
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_reqs", {rd_burst_req, wr_burst_req}, 0);
    chk("rst_state", state_interface_module, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_cnt", rd_cnt_data, 0);
    chk("rst_len", rd_burst_len, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // All four together: order 0,1,2,3 with fixed turnaround.
    run_round(4'b1111, 1'b1, 0);
    // Single data read at 0x80.
    addr_tbl[1] = 28'h80;
    run_round(4'b0010, 1'b0, 0);
    // Single store at 0x2800.
    addr_tbl[2] = 28'h2800;
    run_round(4'b0100, 1'b0, 0);
    // Jump read held long after its burst: exactly one burst, then re-raise gives another.
    g0 = n_grants;
    run_round(4'b1000, 1'b1, 50);
    chk("jmp_hold_bursts", n_grants - g0, 1);
    g0 = n_grants;
    run_round(4'b1000, 1'b1, 0);
    chk("jmp_rearm_bursts", n_grants - g0, 1);

    // Random request sets and hold times.
    for (int r = 0; r < 20; r++) run_round(4'($urandom_range(1, 15)), 1'b1, $urandom_range(0, 4));

    // Timeout: controller silent on a data read.
    ctl_mute = 1'b1;
    addr_tbl[1] = AW'($urandom);
    model_round(4'b0010);
    @(posedge clk); #1;
    drive_addrs();
    data_read_req = 1'b1;
    w = 0;
    while (!rd_burst_req && w < 20) begin @(negedge clk); w++; end
    hi = 0;
    while (rd_burst_req && hi < 1100) begin hi++; @(negedge clk); end
    chk("timeout_req_cycles", hi, 1024);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_grant", grant, 0);
    @(negedge clk);
    chk("timeout_no_regrant", grant, 0);
    @(posedge clk); #1;
    data_read_req = 1'b0;
    repeat (3) @(posedge clk);

    // Reset at beat 5 of a store burst.
    addr_tbl[2] = 28'h2800;
    model_round(4'b0100);
    @(posedge clk); #1;
    drive_addrs();
    data_store_req = 1'b1;
    w = 0;
    while (!wr_burst_req && w < 20) begin @(negedge clk); w++; end
    chk("store_req_seen", wr_burst_req, 1);
    for (int b = 0; b < 5; b++) begin
      @(posedge clk); #1;
      wr_burst_data_req = 1'b1; data_to_ddr = DW'($urandom);
      @(negedge clk);
      chk("wr_data_req_pre_rst", wr_data_req, 1);
      @(posedge clk); #1;
      wr_burst_data_req = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("arst_grant", grant, 0);
    chk("arst_reqs", {rd_burst_req, wr_burst_req}, 0);
    chk("arst_addr", wr_burst_addr, 0);
    chk("arst_len", wr_burst_len, 0);
    chk("arst_state", state_interface_module, 0);
    chk("arst_err", timeout_err, 0);
    chk("arst_cnt", rd_cnt_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    data_store_req = 1'b0;
    m_ptr = 0;
    ctl_mute = 1'b0;
    repeat (2) @(posedge clk);
    // Pointer back at 0: store must beat jump.
    run_round(4'b1100, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
